// File: rtl/os_uart_rx_ctrl.sv
// Oversampled UART receiver: majority-vote each OSR-sample bit window, frame
// start/data/stop, and hand the byte to a valid/ready consumer.
module os_uart_rx_ctrl #(
    parameter int OSR       = 20,
    parameter int VOTE_TH   = 10,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 sample_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OSR + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] OSR_C    = CW'(OSR);
    localparam logic [CW-1:0] VOTE_C   = CW'(VOTE_TH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 prev_s_q, prev_s_d;
    logic [CW-1:0]        ones_q, ones_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic [CW-1:0]        ones_nxt, cnt_nxt;
    logic                 win_done, vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_s_q    <= 1'b0;
            ones_q      <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_s_q    <= prev_s_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_s_d    = prev_s_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Window totals including the sample being accepted this cycle
        ones_nxt = ones_q + CW'(sample_in);
        cnt_nxt  = cnt_q + CW'(1);
        win_done = (cnt_nxt == OSR_C);
        vote     = (ones_nxt >= VOTE_C);

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (sample_en) begin
            prev_s_d = sample_in;
            if (state_q == IDLE) begin
                if (prev_s_q && !sample_in) begin
                    state_d = START;
                    ones_d  = '0;
                    cnt_d   = CW'(1);
                end
            end else if (!win_done) begin
                ones_d = ones_nxt;
                cnt_d  = cnt_nxt;
            end else begin
                ones_d = '0;
                cnt_d  = '0;
                case (state_q)
                    START: begin
                        if (vote) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end
                    end
                    DATA: begin
                        shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + BW'(1);
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        // A same-cycle handshake frees the slot, so it loads instead of overrunning
                        if (!vote) begin
                            frame_err_d = 1'b1;
                        end else if (rx_valid_q && !rx_ready) begin
                            overrun_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_os_uart_rx_ctrl.sv
// Scoreboard bench for os_uart_rx_ctrl: frames built from sample windows,
// expected events queued by the driver and matched by an independent monitor.
module tb_os_uart_rx_ctrl;

    localparam int OSR = 20;
    localparam int TH  = 10;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic          sample_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun, busy;

    os_uart_rx_ctrl #(.OSR(OSR), .VOTE_TH(TH), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .sample_in (sample_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_DATA = 0, EV_FERR = 1, EV_OVR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int            cyc;
        logic [DB-1:0] data;
    } ev_t;

    ev_t           exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            m_valid = 1'b0;
    logic [DB-1:0] m_data = '0;
    int            ready_mode = 0;
    bit            toggle_en = 1'b0;
    bit            pv = 1'b0;
    bit            phs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push_ev(input ev_kind_t k, input logic [DB-1:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic bit pick_ready(input bit last, input bit en);
        case (ready_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return bit'($urandom_range(1, 0));
            default: return last && en;
        endcase
    endfunction

    // One clock cycle; the reference model applies the delivery rules at this edge.
    task automatic step(input bit en, input bit s, input bit last, input bit stop_ok, input logic [DB-1:0] b);
        bit rdy;
        rdy       = pick_ready(last, en);
        rx_ready  = rdy;
        sample_en = en;
        sample_in = s;
        @(posedge clk);
        #1;
        if (en && last) begin
            if (!stop_ok) begin
                push_ev(EV_FERR, m_data);
            end else if (m_valid && !rdy) begin
                push_ev(EV_OVR, m_data);
            end else begin
                m_valid = 1'b1;
                m_data  = b;
                push_ev(EV_DATA, b);
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive_sample(input bit s, input bit last, input bit stop_ok, input logic [DB-1:0] b);
        if (toggle_en) begin
            step(1'b1, s, last, stop_ok, b);
            step(1'b0, bit'($urandom_range(1, 0)), 1'b0, 1'b0, '0);
        end else begin
            step(1'b1, s, last, stop_ok, b);
        end
    endtask

    task automatic send_win(input logic [OSR-1:0] w, input bit last, input bit stop_ok, input logic [DB-1:0] b);
        for (int j = 0; j < OSR; j++) begin
            drive_sample(w[j], last && (j == OSR - 1), stop_ok, b);
        end
    endtask

    function automatic logic [OSR-1:0] mk_win(input int k, input bit first_zero);
        logic [OSR-1:0] w;
        int             n;
        int unsigned    p;
        w = '0;
        n = 0;
        while (n < k) begin
            p = $urandom_range(OSR - 1, first_zero ? 1 : 0);
            if (!w[p]) begin
                w[p] = 1'b1;
                n++;
            end
        end
        return w;
    endfunction

    // style 0: clean windows, 1: marginal 9/10 ones, 2: random ones on the right side of the threshold
    function automatic int ones_for(input bit v, input int style);
        case (style)
            0:       return v ? OSR : 0;
            1:       return v ? TH : TH - 1;
            default: return v ? int'($urandom_range(OSR, TH)) : int'($urandom_range(TH - 1, 0));
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_sample(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input int style, input int stop_k);
        send_win(mk_win((style == 2) ? ones_for(1'b0, 2) : 0, 1'b1), 1'b0, 1'b0, '0);
        for (int i = 0; i < DB; i++) begin
            send_win(mk_win(ones_for(b[i], style), 1'b0), 1'b0, 1'b0, '0);
        end
        send_win(mk_win(stop_k, 1'b0), 1'b1, stop_k >= TH, b);
        idle(2);
    endtask

    task automatic drain();
        ready_mode = 1;
        idle(3);
        ready_mode = 0;
    endtask

    task automatic match(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected no event", k, rx_data, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_data", rx_data, e.data);
        end
    endtask

    // Monitor: decodes output activity into events, independent of the driver
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv  = 1'b0;
                phs = 1'b0;
            end else begin
                check("flags_exclusive", frame_err && overrun, 0);
                if (frame_err) match(EV_FERR);
                if (overrun) match(EV_OVR);
                if (rx_valid && (!pv || phs)) match(EV_DATA);
                pv  = rx_valid;
                phs = rx_valid && rx_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit             saw_busy;
        logic [OSR-1:0] w;
        int             r;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Line held low straight out of reset never looks like a start edge
        saw_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, '0);
            if (busy) saw_busy = 1'b1;
        end
        check("low_after_reset_busy", saw_busy, 0);
        idle(4);

        ready_mode = 0;
        send_frame(8'hA5, 0, OSR);
        check("a5_rx_valid", rx_valid, 1);
        check("a5_rx_data", rx_data, 8'hA5);
        drain();

        send_frame(8'h3C, 1, OSR);
        drain();

        // Start window: 5 zeros then 15 ones is a false start
        w = '1;
        w[4:0] = '0;
        send_win(w, 1'b0, 1'b0, '0);
        check("false_start_busy", busy, 0);
        check("false_start_valid", rx_valid, 0);
        idle(3);

        send_frame(8'h55, 0, 0);
        check("ferr_valid_low", rx_valid, 0);
        send_frame(8'h12, 0, OSR);
        drain();

        send_frame(8'h11, 0, OSR);
        send_frame(8'h22, 0, OSR);
        check("ovr_keeps_old", rx_data, 8'h11);
        ready_mode = 3;
        send_frame(8'h22, 0, OSR);
        check("load_on_handshake", rx_data, 8'h22);
        drain();

        toggle_en = 1'b1;
        send_frame(8'h7E, 0, OSR);
        toggle_en = 1'b0;
        check("toggle_en_data", rx_data, 8'h7E);
        drain();

        for (int it = 0; it < 30; it++) begin
            toggle_en  = bit'($urandom_range(1, 0));
            ready_mode = 2;
            r = int'($urandom_range(9, 0));
            if (r == 0) begin
                send_win(mk_win(int'($urandom_range(OSR - 1, TH)), 1'b1), 1'b0, 1'b0, '0);
                check("rand_false_start_busy", busy, 0);
            end else if (r == 1) begin
                send_frame(DB'($urandom), 2, int'($urandom_range(TH - 1, 0)));
            end else begin
                send_frame(DB'($urandom), 2, int'($urandom_range(OSR, TH)));
            end
            idle(int'($urandom_range(5, 1)));
        end
        toggle_en = 1'b0;
        drain();

        // Asynchronous reset in the middle of the data bits
        ready_mode = 0;
        send_frame(8'h5A, 0, OSR);
        send_win(mk_win(0, 1'b1), 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) send_win(mk_win(OSR, 1'b0), 1'b0, 1'b0, '0);
        check("mid_data_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_busy", busy, 0);
        m_valid = 1'b0;
        m_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        send_frame(8'hC3, 2, OSR);
        drain();

        idle(5);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
